// File: rtl/current_monitor_pkg.sv
// Shared types and helpers for the TLI4970 current-monitor post-processing path.
package current_monitor_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRIP = 2'd2
    } cm_state_e;

    // Magnitude of a two's-complement sample; the most negative code saturates.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (x[SAMPLE_W-1])
            r = SAMPLE_W'(-x);
        else
            r = x;
        return r;
    endfunction

endpackage

// File: rtl/current_moving_avg.sv
// Circular-buffer moving average over 2^AVG_LOG2 samples: accumulator updated
// one cycle after the sample, average registered one cycle later.
module current_moving_avg
    import current_monitor_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_valid,
    output logic signed [SAMPLE_W-1:0] o_avg,
    output logic                       o_avg_valid,
    output logic                       o_fill_done
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;

    logic signed [SAMPLE_W-1:0] r_buf [DEPTH];
    logic [AVG_LOG2-1:0]        r_ptr;
    logic [AVG_LOG2-1:0]        r_fill_cnt;
    logic                       r_full;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_acc_vld;
    logic signed [SAMPLE_W-1:0] r_avg;
    logic                       r_avg_vld;

    logic signed [ACC_W-1:0]    w_new;
    logic signed [ACC_W-1:0]    w_old;
    logic                       w_fill_done;

    assign w_new = {{AVG_LOG2{i_sample[SAMPLE_W-1]}}, i_sample};
    // While filling, the slot being written holds no live sample.
    assign w_old = r_full ? {{AVG_LOG2{r_buf[r_ptr][SAMPLE_W-1]}}, r_buf[r_ptr]} : '0;
    assign w_fill_done = i_valid && !r_full && (r_fill_cnt == AVG_LOG2'(DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_valid)
            r_buf[r_ptr] <= i_sample;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_fill_cnt <= '0;
            r_full     <= 1'b0;
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
        end else if (i_flush) begin
            r_ptr      <= '0;
            r_fill_cnt <= '0;
            r_full     <= 1'b0;
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
        end else begin
            r_acc_vld <= i_valid && (r_full || w_fill_done);
            if (i_valid) begin
                r_acc <= r_acc + w_new - w_old;
                r_ptr <= r_ptr + 1'b1;
                if (!r_full) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (w_fill_done)
                        r_full <= 1'b1;
                end
            end
        end
    end

    // Arithmetic shift floors toward -inf; the window sum always fits the result.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= r_acc_vld;
            if (r_acc_vld)
                r_avg <= SAMPLE_W'(r_acc >>> AVG_LOG2);
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_avg_vld;
    assign o_fill_done = w_fill_done;

endmodule

// File: rtl/tli4970_current_monitor.sv
// TLI4970 current monitor: moving average, latched overcurrent trip, sample watchdog.
// Define CURRENT_MONITOR_PEAK_EN to build the peak |current_in| register.
module tli4970_current_monitor
    import current_monitor_pkg::*;
#(
    parameter int AVG_LOG2       = 3,
    parameter int TRIP_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic signed [SAMPLE_W-1:0] i_current_in,
    input  logic                       i_current_valid,
    input  logic [SAMPLE_W-1:0]        i_trip_threshold,
    input  logic                       i_trip_clear,
    output logic signed [SAMPLE_W-1:0] o_avg_current,
    output logic                       o_avg_valid,
    output logic                       o_overcurrent,
    output logic                       o_sensor_fault,
    output logic [SAMPLE_W-1:0]        o_peak_abs
);

    localparam int CNT_W = $clog2(TRIP_COUNT + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRIP_COUNT);
    localparam logic [WD_W-1:0]  WD_FIRE = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    cm_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_oc;
    logic [WD_W-1:0]    r_wd;
    logic               r_fault;

    logic signed [SAMPLE_W-1:0] w_avg;
    logic                       w_avg_valid;
    logic                       w_fill_done;
    logic [SAMPLE_W-1:0]        w_mag;
    logic                       w_over;
    logic                       w_trip;
    logic                       w_timeout;
    logic [CNT_W-1:0]           w_cnt_inc;

    current_moving_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_timeout),
        .i_sample   (i_current_in),
        .i_valid    (i_current_valid),
        .o_avg      (w_avg),
        .o_avg_valid(w_avg_valid),
        .o_fill_done(w_fill_done)
    );

    // A sample arriving in the firing cycle wins over the timeout.
    assign w_timeout = !i_current_valid && (r_wd == WD_FIRE);

    // r_wd holds the number of cycles since the last accepted sample.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wd    <= '0;
            r_fault <= 1'b0;
        end else if (i_current_valid) begin
            r_wd    <= WD_W'(1);
            r_fault <= 1'b0;
        end else begin
            if (r_wd != WD_MAX)
                r_wd <= r_wd + 1'b1;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign w_mag     = sat_abs(w_avg);
    assign w_over    = w_avg_valid && (w_mag > i_trip_threshold);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_trip    = w_over && (w_cnt_inc == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_oc    <= 1'b0;
        end else begin
            if (w_trip) begin
                r_oc  <= 1'b1;
                r_cnt <= w_cnt_inc;
            end else if (i_trip_clear) begin
                r_oc  <= 1'b0;
                r_cnt <= '0;
            end else if (w_timeout) begin
                r_cnt <= '0;
            end else if (w_avg_valid) begin
                r_cnt <= w_over ? w_cnt_inc : '0;
            end

            if (w_timeout)
                r_state <= ST_FILL;
            else if (w_trip)
                r_state <= ST_TRIP;
            else begin
                case (r_state)
                    ST_FILL: if (w_fill_done) r_state <= ST_RUN;
                    default: if (i_trip_clear) r_state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef CURRENT_MONITOR_PEAK_EN
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_in_mag;

    assign w_in_mag = sat_abs(i_current_in);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_peak <= '0;
        else if (i_trip_clear)
            r_peak <= '0;
        else if (i_current_valid && (w_in_mag > r_peak))
            r_peak <= w_in_mag;
    end

    assign o_peak_abs = r_peak;
`else
    assign o_peak_abs = '0;
`endif

    assign o_avg_current  = w_avg;
    assign o_avg_valid    = w_avg_valid;
    assign o_overcurrent  = r_oc;
    assign o_sensor_fault = r_fault;

endmodule

// File: tb/tb_tli4970_current_monitor.sv
// Directed + randomized bench for tli4970_current_monitor against a window/queue model.
module tb_tli4970_current_monitor;

    localparam int AVG_LOG2 = 3;
    localparam int N        = 1 << AVG_LOG2;
    localparam int TC       = 4;
    localparam int T        = 32000;

    logic               clk            = 1'b0;
    logic               rst            = 1'b1;
    logic signed [15:0] current_in     = '0;
    logic               current_valid  = 1'b0;
    logic [15:0]        trip_threshold = '0;
    logic               trip_clear     = 1'b0;
    logic signed [15:0] avg_current;
    logic               avg_valid;
    logic               overcurrent;
    logic               sensor_fault;
    logic [15:0]        peak_abs;

    tli4970_current_monitor #(
        .AVG_LOG2(AVG_LOG2),
        .TRIP_COUNT(TC),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_current_in    (current_in),
        .i_current_valid (current_valid),
        .i_trip_threshold(trip_threshold),
        .i_trip_clear    (trip_clear),
        .o_avg_current   (avg_current),
        .o_avg_valid     (avg_valid),
        .o_overcurrent   (overcurrent),
        .o_sensor_fault  (sensor_fault),
        .o_peak_abs      (peak_abs)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int cyc; int val; } ev_t;

    // Reference model: the live window as a queue, scheduled averages, trip state.
    int  win[$];
    ev_t evq[$];
    int  cyc, last_valid, consec, last_avg, m_peak, thr;
    bit  m_oc, m_fault;
    int  n_total = 0;
    int  n_pass  = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat_mag(input int x);
        int a;
        a = (x < 0) ? -x : x;
        return (a > 32767) ? 32767 : a;
    endfunction

    function automatic int floor_avg();
        int sum, q;
        sum = 0;
        foreach (win[i]) sum += win[i];
        q = sum / N;
        if (sum < 0 && q * N != sum) q--;
        return q;
    endfunction

    function automatic bit would_trip_now();
        if (evq.size() > 0 && evq[0].cyc == cyc)
            return (sat_mag(evq[0].val) > thr) && (consec >= TC - 1);
        return 1'b0;
    endfunction

    task automatic model_reset();
        win.delete();
        evq.delete();
        cyc = 0; last_valid = 0; consec = 0; last_avg = 0;
        m_peak = 0; m_oc = 1'b0; m_fault = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        current_valid = 1'b0;
        trip_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance the model.
    task automatic step(input bit v, input int s, input bit clr);
        bit ev, over, trip;
        int ev_val;
        ev = 1'b0; ev_val = 0; over = 1'b0; trip = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            ev = 1'b1;
            ev_val = evq[0].val;
            void'(evq.pop_front());
            last_avg = ev_val;
        end
        check("avg_valid", avg_valid, ev);
        check("avg_current", avg_current, last_avg);
        check("overcurrent", overcurrent, m_oc);
        check("sensor_fault", sensor_fault, m_fault);
        check("peak_abs", peak_abs, m_peak);

        current_valid  = v;
        current_in     = 16'(s);
        trip_clear     = clr;
        trip_threshold = 16'(thr);

        if (ev) begin
            over   = sat_mag(ev_val) > thr;
            consec = over ? ((consec + 1 > TC) ? TC : consec + 1) : 0;
            trip   = over && (consec == TC);
        end
        if (trip) m_oc = 1'b1;
        else if (clr) begin
            m_oc = 1'b0;
            consec = 0;
        end
        if (v) begin
            m_fault = 1'b0;
            last_valid = cyc;
            win.push_back(s);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) evq.push_back('{cyc + 2, floor_avg()});
        end else if (cyc + 1 - last_valid == T) begin
            m_fault = 1'b1;
            win.delete();
            consec = 0;
        end
`ifdef CURRENT_MONITOR_PEAK_EN
        if (clr) m_peak = 0;
        else if (v && sat_mag(s) > m_peak) m_peak = sat_mag(s);
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        bit hit, c;
        int base, s;
        thr = 1000;
        do_reset();
        check("reset_avg", avg_current, 0);
        check("reset_avg_valid", avg_valid, 0);
        check("reset_oc", overcurrent, 0);
        check("reset_fault", sensor_fault, 0);
        check("reset_peak", peak_abs, 0);

        repeat (N) step(1'b1, 100, 1'b0);
        idle(3);
        check("first_avg", avg_current, 100);

        repeat (N - 1) step(1'b1, -3, 1'b0);
        step(1'b1, -4, 1'b0);
        idle(3);
        check("floor_avg", avg_current, -4);

        thr = 500;
        repeat (N + 4) step(1'b1, 600, 1'b0);
        idle(3);
        check("trip_set", overcurrent, 1);

        step(1'b0, 0, 1'b1);
        check("clear_alone", overcurrent, 0);

        // Three over-threshold averages, one at 400, then a fresh run of four.
        repeat (3) step(1'b1, 600, 1'b0);
        step(1'b1, -1000, 1'b0);
        idle(3);
        check("avg_400", avg_current, 400);
        check("no_trip_after_dip", overcurrent, 0);
        repeat (12) step(1'b1, 600, 1'b0);
        idle(3);
        check("trip_after_rerun", overcurrent, 1);

        // trip_clear in the very cycle the trip qualifies.
        step(1'b0, 0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            c = would_trip_now();
            step(1'b1, 600, c);
            if (c) hit = 1'b1;
        end
        idle(3);
        check("trip_beats_clear", overcurrent, 1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                base = int'($urandom_range(0, 5000)) - 2500;
                thr  = int'($urandom_range(0, 2000));
            end
            s = base + int'($urandom_range(0, 400)) - 200;
            if ($urandom_range(0, 19) == 0) s = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
            step($urandom_range(0, 9) < 7, s, $urandom_range(0, 99) == 0);
        end

        step(1'b0, 0, 1'b1);
        thr = 500;
        repeat (12) step(1'b1, 600, 1'b0);
        idle(T);
        check("timeout_fault", sensor_fault, 1);
        check("timeout_keeps_oc", overcurrent, 1);
        step(1'b1, 100, 1'b0);
        check("fault_cleared", sensor_fault, 0);
        repeat (N - 1) step(1'b1, 100, 1'b0);
        idle(3);
        check("refill_avg", avg_current, 100);

        // A sample in the firing cycle suppresses the timeout.
        step(1'b1, 100, 1'b0);
        idle(T - 2);
        step(1'b1, 100, 1'b0);
        idle(3);
        check("valid_beats_timeout", sensor_fault, 0);

        do_reset();
        check("midrun_reset_avg", avg_current, 0);
        check("midrun_reset_oc", overcurrent, 0);
        check("midrun_reset_fault", sensor_fault, 0);
        thr = 32766;
        repeat (N + 3) step(1'b1, -32768, 1'b0);
        idle(3);
        check("neg_full_avg", avg_current, -32768);
        check("neg_full_trip", overcurrent, 1);
`ifdef CURRENT_MONITOR_PEAK_EN
        check("neg_full_peak", peak_abs, 32767);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
